// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory.
// The fetch side (i_*) and the data side (d_*) share one memory port. The data
// side has fixed priority, but a saturating streak counter guarantees the fetch
// side a grant after STARVE_MAX back-to-back data grants while it is waiting.
// Every access takes three cycles: IDLE (arbitrate) -> ACCESS (strobe) -> RESP
// (capture read data), with ready pulsing in the cycle after RESP.

module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  // Fetch side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,

  // Data side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,

  // Memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  // Pipeline stalls
  output logic              stall_i,
  output logic              stall_d
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [3:0] StreakMax = 4'(STARVE_MAX);

  // Mask that clears the byte offset within a 32-bit word.
  localparam logic [ADDR_W-1:0] WordMask = ~ADDR_W'(3);

  state_e              state_q;
  logic [3:0]          d_streak_q;
  logic                sel_d_q;     // winner of the in-flight access is the data side
  logic                we_q;        // in-flight access is a store
  logic                i_ready_q;
  logic                d_ready_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic                any_req;
  logic                grant_d;
  logic                i_starved;
  logic [ADDR_W-1:0]   grant_addr;
  logic [DATA_W-1:0]   grant_wdata;
  logic                grant_we;
  logic [3:0]          d_streak_d;

  // Arbitration decision and the streak counter's next value for an IDLE grant.
  always_comb begin
    any_req     = i_req | d_req;
    i_starved   = i_req & (d_streak_q == StreakMax);
    grant_d     = d_req & ~i_starved;
    grant_addr  = (grant_d ? d_addr : i_addr) & WordMask;
    grant_wdata = grant_d ? d_wdata : '0;
    grant_we    = grant_d & d_we;

    d_streak_d = '0;
    if (grant_d && i_req) begin
      // Only D grants that make I wait count towards starvation.
      d_streak_d = (d_streak_q == StreakMax) ? d_streak_q : d_streak_q + 4'd1;
    end
  end

  // Access sequencer: state, latched winner, registered memory strobes and responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      d_streak_q  <= '0;
      sel_d_q     <= 1'b0;
      we_q        <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Ready is a single-cycle pulse.
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            sel_d_q     <= grant_d;
            we_q        <= grant_we;
            d_streak_q  <= d_streak_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_we;
            mem_addr_q  <= grant_addr;
            mem_wdata_q <= grant_wdata;
            state_q     <= StAccess;
          end
        end

        StAccess: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          state_q     <= StResp;
        end

        StResp: begin
          // mem_rdata is valid now, one cycle after the read strobe.
          if (sel_d_q) begin
            d_ready_q <= 1'b1;
            if (!we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end else begin
            i_ready_q <= 1'b1;
            i_rdata_q <= mem_rdata;
          end
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // A requester stalls until the cycle its ready pulses.
  assign stall_i = i_req & ~i_ready_q;
  assign stall_d = d_req & ~d_ready_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of all address ports.
REQ-002 Parameter DATA_W, default 32: width of all data ports.
REQ-003 Parameter STARVE_MAX, default 4, legal range 1..15: maximum consecutive D grants while i_req is pending.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. Ports are clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 i_req  in  1  fetch-side read request; held high with i_addr stable until i_ready.
REQ-008 i_addr  in  ADDR_W  fetch address.
REQ-009 i_ready  out  1  one-cycle pulse: fetch access complete, i_rdata valid.
REQ-010 i_rdata  out  DATA_W  fetch read data.
REQ-011 d_req  in  1  data-side request; held high with d_we, d_addr and d_wdata stable until d_ready.
REQ-012 d_we  in  1  1 = store, 0 = load.
REQ-013 d_addr  in  ADDR_W  data address.
REQ-014 d_wdata  in  DATA_W  store data.
REQ-015 d_ready  out  1  one-cycle pulse: data access complete, d_rdata valid for loads.
REQ-016 d_rdata  out  DATA_W  load data.
REQ-017 mem_en  out  1  single-port memory access strobe.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  ADDR_W  word-aligned memory address.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.
REQ-022 stall_i  out  1  fetch stage must hold.
REQ-023 stall_d  out  1  memory stage must hold.

Function
REQ-024 The FSM SHALL have states IDLE, ACCESS and RESP, with registered state and registered mem_* outputs.
REQ-025 In IDLE with any request present: latch the winner and its address, data and we, then go to ACCESS; with no request, stay in IDLE.
REQ-026 Arbitration SHALL be fixed D-over-I priority, except I wins when i_req=1 and d_streak==STARVE_MAX.
REQ-027 d_streak (4 bits) SHALL increment on each D grant made while i_req=1, saturate at STARVE_MAX, and clear on any I grant or on any D grant made while i_req=0.
REQ-028 ACCESS SHALL be exactly one cycle with the following outputs, then go to RESP:
  - mem_en=1
  - mem_we = latched we (forced to 0 for I)
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}
  - mem_wdata = latched wdata
REQ-029 Outside ACCESS, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0.
REQ-030 RESP SHALL last one cycle and then return to IDLE.
  - The winner's ready pulses.
  - The winner's rdata is loaded from mem_rdata (reads only; a store leaves d_rdata unchanged).
REQ-031 Latency SHALL be 3 cycles: a request sampled in IDLE at edge N gives ready high in the cycle after edge N+2; the minimum issue interval is 3 cycles.
REQ-032 i_rdata and d_rdata SHALL hold their last value until the next read completion on that side.
REQ-033 stall_i = i_req & ~i_ready and stall_d = d_req & ~d_ready, combinationally.
REQ-034 Simultaneous i_req and d_req in IDLE SHALL grant exactly one side; the loser stays pending, with stall held.
REQ-035 A request whose req drops before its ready SHALL still complete once granted; an ungranted dropped request is never issued.
REQ-036 i_ready and d_ready SHALL never be high in the same cycle.

Reset
REQ-037 rst=0 SHALL immediately (asynchronously) apply the following, abandoning any in-flight access:
  - state=IDLE
  - d_streak=0
  - all latched fields, i_rdata and d_rdata = 0
  - i_ready=0, d_ready=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
REQ-038 After rst rises, the first arbitration SHALL occur on the first rising clk edge.

Verification
REQ-039 i_req=1, i_addr=0x0000_0006, mem returns 0x1234_5678 -> mem_addr=0x0000_0004, mem_we=0; i_ready pulses 3 cycles later with i_rdata=0x1234_5678.
REQ-040 d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF -> one ACCESS cycle with mem_we=1, mem_wdata=0xDEAD_BEEF; d_ready pulses; d_rdata unchanged.
REQ-041 i_req and d_req (load) both high in IDLE -> D served first; stall_i stays 1 until the I access completes 3 cycles after d_ready.
REQ-042 i_req and d_req held continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I; each ready spaced 3 cycles apart.
REQ-043 rst=0 during ACCESS of a store -> mem_en=0 immediately; no d_ready; after release, the held d_req re-arbitrates and completes with a fresh 3-cycle latency.
